// File: rtl/bcd_scan_counter_if.sv
// Board-facing signal bundle for bcd_scan_counter: switch controls in,
// BCD count and multiplexed seven-segment display pins out.
interface bcd_scan_counter_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic                  forward;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic [4*DIGITS-1:0]   count;
  logic                  wrap;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;

  // Controls are level/strobe inputs sampled on every rising clock edge;
  // there is no valid/ready handshake, every output is a registered level.
  modport master (
    output enable, forward, load, load_value,
    input  count, wrap, seg, dp, an
  );

  modport slave (
    input  enable, forward, load, load_value,
    output count, wrap, seg, dp, an
  );
endinterface

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with tick prescaler and multiplexed 7-segment driver.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero digit.
module bcd_scan_counter #(
  parameter int DIGITS  = 4,
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 1,
  parameter int SCAN_HZ = 1000
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  bcd_scan_counter_if.slave bus
);

  localparam int TICK_RAW = CLK_HZ / TICK_HZ;
  localparam int SCAN_RAW = CLK_HZ / SCAN_HZ;
  localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
  localparam int SCAN_DIV = (SCAN_RAW < 1) ? 1 : SCAN_RAW;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SDW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [TW-1:0]          presc;
  logic [SDW-1:0]         scan_div;
  logic [SW-1:0]          scan_idx;
  logic [4*DIGITS-1:0]    count_q;
  logic [4*DIGITS-1:0]    stepped;
  logic [4*DIGITS-1:0]    clamped;
  logic                   carry;
  logic [3:0]             d;
  logic                   wrap_q;
  logic [6:0]             seg_q;
  logic                   dp_q;
  logic [DIGITS-1:0]      an_q;
  logic [DIGITS-1:0]      blank;
  logic [3:0]             cur_digit;
  logic                   tick;
  logic                   scan_tc;

  assign tick    = bus.enable && (presc == TW'(TICK_DIV - 1));
  assign scan_tc = (scan_div == SDW'(SCAN_DIV - 1));

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  // Ripple step: a carry/borrow surviving past the top digit means the
  // whole count rolled over (all 9s up, or all 0s down).
  always_comb begin
    stepped = count_q;
    carry   = 1'b1;
    d       = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      d = count_q[4*i +: 4];
      if (carry) begin
        if (bus.forward) begin
          if (d == 4'd9) begin
            stepped[4*i +: 4] = 4'd0;
          end else begin
            stepped[4*i +: 4] = d + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            stepped[4*i +: 4] = 4'd9;
          end else begin
            stepped[4*i +: 4] = d - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      clamped[4*i +: 4] = (bus.load_value[4*i +: 4] > 4'd9) ? 4'd9 : bus.load_value[4*i +: 4];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lead;
  always_comb begin
    blank = '0;
    lead  = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lead     = lead & (count_q[4*i +: 4] == 4'd0);
      blank[i] = lead;
    end
  end
`else
  assign blank = '0;
`endif

  assign cur_digit = count_q[{scan_idx, 2'b00} +: 4];

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      presc   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else if (bus.load) begin
      presc   <= '0;
      count_q <= clamped;
      wrap_q  <= 1'b0;
    end else begin
      if (bus.enable) begin
        presc <= tick ? '0 : presc + TW'(1);
      end
      if (tick) begin
        count_q <= stepped;
        wrap_q  <= carry;
      end else begin
        wrap_q  <= 1'b0;
      end
    end
  end

  // Scan runs regardless of enable so the display keeps refreshing while paused.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      scan_div <= '0;
      scan_idx <= '0;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      an_q     <= '1;
    end else begin
      scan_div <= scan_tc ? '0 : scan_div + SDW'(1);
      if (scan_tc) begin
        scan_idx <= (scan_idx == SW'(DIGITS - 1)) ? '0 : scan_idx + SW'(1);
      end
      an_q  <= ~(DIGITS'(1) << scan_idx);
      seg_q <= blank[scan_idx] ? 7'h7F : decode(cur_digit);
      dp_q  <= ~((scan_idx == '0) && !bus.enable);
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.an    = an_q;

endmodule
